// File: rtl/ed25519_sigverify_res_q_pkg.sv
// Shared types for the signature-verify result path: compare-stage record and
// result-queue statistics.
package wd_sigverify;

  localparam int unsigned SV_META_W     = 63;
  localparam int unsigned SV_RESQ_CNT_W = 32;

  typedef struct packed {
    logic [SV_META_W-1:0] m;
    logic                 res;
  } sv_meta7_t;

  typedef struct packed {
    logic [SV_RESQ_CNT_W-1:0] pass;
    logic [SV_RESQ_CNT_W-1:0] fail;
    logic [SV_RESQ_CNT_W-1:0] drop;
  } sv_resq_stat_t;

  // Saturating increment for statistics counters.
  function automatic logic [SV_RESQ_CNT_W-1:0] sat_inc(input logic [SV_RESQ_CNT_W-1:0] c);
    return (&c) ? c : c + SV_RESQ_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ed25519_sigverify_res_q_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module wd_sdp_ram #(
  parameter int unsigned DEPTH = 63,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ed25519_sigverify_res_q.sv
// Result queue behind the signature-verify compare stage: FWFT queue with an
// output register as the last slot, registered throttle and delivery statistics.
module ed25519_sigverify_res_q
  import wd_sigverify::*;
#(
  parameter int unsigned D  = 64,
  parameter int unsigned AF = D - 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_v,
  input  sv_meta7_t                i_m,
  output logic                     o_w,
  output logic                     o_v,
  input  logic                     o_r,
  output sv_meta7_t                o_m,
  output logic [SV_RESQ_CNT_W-1:0] cnt_pass,
  output logic [SV_RESQ_CNT_W-1:0] cnt_fail,
  output logic [SV_RESQ_CNT_W-1:0] cnt_drop,
  output logic                     ovf
);

  localparam int unsigned RD = D - 1;
  localparam int unsigned PW = $clog2(RD);
  localparam int unsigned OW = $clog2(D + 1);
  localparam int unsigned MW = $bits(sv_meta7_t);

  logic [OW-1:0] occ_q, occ_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          out_v_q, out_v_d;
  sv_meta7_t     out_m_q, out_m_d;
  logic          ow_q, ow_d;
  sv_resq_stat_t stat_q, stat_d;
  logic          ovf_q, ovf_d;
  logic          fwd_v_q, fwd_v_d;
  sv_meta7_t     fwd_m_q, fwd_m_d;

  logic          pop_c, push_c, drop_c, full_c, ram_empty_c, ram_we_c;
  logic [MW-1:0] ram_rdata;
  sv_meta7_t     head_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RD - 1)) ? '0 : p + PW'(1);
  endfunction

  wd_sdp_ram #(.DEPTH(RD), .WIDTH(MW)) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .waddr (wr_ptr_q),
    .wdata (i_m),
    .raddr (rd_ptr_d),
    .rdata (ram_rdata)
  );

  // A write landing on the address being read returns stale data; forward it.
  assign head_c = fwd_v_q ? fwd_m_q : sv_meta7_t'(ram_rdata);

  always_comb begin
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    out_v_d  = out_v_q;
    out_m_d  = out_m_q;
    stat_d   = stat_q;
    ovf_d    = ovf_q;
    ram_we_c = 1'b0;

    full_c      = (occ_q == OW'(D));
    pop_c       = out_v_q & o_r;
    push_c      = i_v & (~full_c | pop_c);
    drop_c      = i_v & full_c & ~pop_c;
    ram_empty_c = ((occ_q - OW'(out_v_q)) == '0);

    if (pop_c) begin
      if (!ram_empty_c) begin
        out_m_d  = head_c;
        rd_ptr_d = ptr_inc(rd_ptr_q);
        ram_we_c = push_c;
      end else if (push_c) begin
        out_m_d = i_m;
      end else begin
        out_v_d = 1'b0;
      end
      if (out_m_q.res) stat_d.pass = sat_inc(stat_q.pass);
      else             stat_d.fail = sat_inc(stat_q.fail);
    end else if (push_c) begin
      if (!out_v_q) begin
        out_v_d = 1'b1;
        out_m_d = i_m;
      end else begin
        ram_we_c = 1'b1;
      end
    end

    if (drop_c) begin
      stat_d.drop = sat_inc(stat_q.drop);
      ovf_d       = 1'b1;
    end

    if (ram_we_c) wr_ptr_d = ptr_inc(wr_ptr_q);

    occ_d   = occ_q + OW'(push_c) - OW'(pop_c);
    ow_d    = (occ_d >= OW'(AF));
    fwd_v_d = ram_we_c & (wr_ptr_q == rd_ptr_d);
    fwd_m_d = i_m;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      out_v_q  <= 1'b0;
      out_m_q  <= '0;
      ow_q     <= 1'b0;
      stat_q   <= '0;
      ovf_q    <= 1'b0;
      fwd_v_q  <= 1'b0;
      fwd_m_q  <= '0;
    end else begin
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      out_v_q  <= out_v_d;
      out_m_q  <= out_m_d;
      ow_q     <= ow_d;
      stat_q   <= stat_d;
      ovf_q    <= ovf_d;
      fwd_v_q  <= fwd_v_d;
      fwd_m_q  <= fwd_m_d;
    end
  end

  assign o_w      = ow_q;
  assign o_v      = out_v_q;
  assign o_m      = out_m_q;
  assign cnt_pass = stat_q.pass;
  assign cnt_fail = stat_q.fail;
  assign cnt_drop = stat_q.drop;
  assign ovf      = ovf_q;

endmodule
